pixel_array_sequencer: RTL and testbench

- Frame-level controller for the digital pixel array.
- Drives the array's global control pins (POWER_ENABLE, ERASE, EXPOSE, WRITE_ENABLE, COUNTER_RESET, COUNTER_CLOCK, READ_RESET, READ_CLK_IN) through one complete frame: erase, expose, ramp conversion, row readout.
- Sits between the top-level system control and the array. Only DATA_OUT and DATA_OUT_CLK bypass it.

---
 rtl/pixel_array_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_pixel_array_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_sequencer.sv
// rtl/pixel_array_sequencer.sv - frame-level control sequencer for the digital pixel array
// Optional feature macro: PIXEL_ARRAY_SEQUENCER_FRAME_COUNTER_EN (completed-frame counter on FRAME_COUNT)
module pixel_array_sequencer #(
  parameter int HEIGHT                 = 2,
  parameter int WIDTH                  = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int ERASE_CYCLES           = 4
) (
  input  logic        SYSTEM_CLK,
  input  logic        SYSTEM_RESET,
  input  logic        START,
  input  logic        ABORT,
  input  logic        CONTINUOUS,
  input  logic [15:0] EXPOSE_TIME,
  output logic        POWER_ENABLE,
  output logic        ERASE,
  output logic        EXPOSE,
  output logic        WRITE_ENABLE,
  output logic        COUNTER_RESET,
  output logic        COUNTER_CLOCK,
  output logic        READ_RESET,
  output logic        READ_CLK_IN,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_COUNT
);

  localparam int N_READS     = HEIGHT * ((WIDTH + OUTPUT_BUS_PIXEL_WIDTH - 1) / OUTPUT_BUS_PIXEL_WIDTH);
  localparam int CONV_CYCLES = 2 * (2 ** BIT_DEPTH);
  localparam int READ_CYCLES = 2 * N_READS;
  localparam int MAX_CR      = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
  localparam int MAX_CRE     = (MAX_CR > ERASE_CYCLES) ? MAX_CR : ERASE_CYCLES;
  localparam int TIMER_MAX   = (MAX_CRE > 65535) ? MAX_CRE : 65535;
  localparam int TW          = $clog2(TIMER_MAX + 1);

  // Timers are loaded with (phase length - 1) and the phase ends when they reach zero
  localparam logic [TW-1:0] ERASE_LOAD = TW'(ERASE_CYCLES - 1);
  localparam logic [TW-1:0] CONV_LOAD  = TW'(CONV_CYCLES - 1);
  localparam logic [TW-1:0] READ_LOAD  = TW'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONV_RST,
    ST_CONVERT,
    ST_RD_RST,
    ST_READOUT,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   exp_len_q, exp_len_d;
  logic [15:0]   exp_latch;

  logic power_enable_q, power_enable_d;
  logic erase_q, erase_d;
  logic expose_q, expose_d;
  logic write_enable_q, write_enable_d;
  logic counter_reset_q, counter_reset_d;
  logic counter_clock_q, counter_clock_d;
  logic read_reset_q, read_reset_d;
  logic read_clk_in_q, read_clk_in_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  // A zero exposure request still exposes for one cycle
  assign exp_latch = (EXPOSE_TIME == 16'd0) ? 16'd1 : EXPOSE_TIME;

  // Next-state, phase timer and exposure latch; ABORT overrides everything
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    exp_len_d = exp_len_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_ERASE;
          timer_d   = ERASE_LOAD;
          exp_len_d = exp_latch;
        end
      end
      ST_ERASE: begin
        if (timer_q == '0) begin
          state_d = ST_EXPOSE;
          timer_d = TW'(exp_len_q) - TW'(1);
        end
      end
      ST_EXPOSE: begin
        if (timer_q == '0) begin
          state_d = ST_CONV_RST;
          timer_d = '0;
        end
      end
      ST_CONV_RST: begin
        state_d = ST_CONVERT;
        timer_d = CONV_LOAD;
      end
      ST_CONVERT: begin
        if (timer_q == '0) begin
          state_d = ST_RD_RST;
          timer_d = '0;
        end
      end
      ST_RD_RST: begin
        state_d = ST_READOUT;
        timer_d = READ_LOAD;
      end
      ST_READOUT: begin
        if (timer_q == '0) begin
          state_d = ST_DONE;
          timer_d = '0;
        end
      end
      ST_DONE: begin
        if (CONTINUOUS) begin
          state_d   = ST_ERASE;
          timer_d   = ERASE_LOAD;
          exp_len_d = exp_latch;
        end else begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (ABORT) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end
  end

  // Output decode from the current phase; clock phases follow timer parity (odd load -> starts high, ends low)
  always_comb begin
    power_enable_d  = 1'b0;
    erase_d         = 1'b0;
    expose_d        = 1'b0;
    write_enable_d  = 1'b0;
    counter_reset_d = 1'b0;
    counter_clock_d = 1'b0;
    read_reset_d    = 1'b0;
    read_clk_in_d   = 1'b0;
    busy_d          = 1'b0;
    frame_done_d    = 1'b0;
    if (!ABORT) begin
      busy_d = (state_q != ST_IDLE);
      case (state_q)
        ST_ERASE:    erase_d = 1'b1;
        ST_EXPOSE:   expose_d = 1'b1;
        ST_CONV_RST: begin
          counter_reset_d = 1'b1;
          power_enable_d  = 1'b1;
          write_enable_d  = 1'b1;
        end
        ST_CONVERT: begin
          power_enable_d  = 1'b1;
          write_enable_d  = 1'b1;
          counter_clock_d = timer_q[0];
        end
        ST_RD_RST:   read_reset_d = 1'b1;
        ST_READOUT:  read_clk_in_d = timer_q[0];
        ST_DONE:     frame_done_d = 1'b1;
        default:     busy_d = busy_d;
      endcase
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      exp_len_q       <= 16'd1;
      power_enable_q  <= 1'b0;
      erase_q         <= 1'b0;
      expose_q        <= 1'b0;
      write_enable_q  <= 1'b0;
      counter_reset_q <= 1'b0;
      counter_clock_q <= 1'b0;
      read_reset_q    <= 1'b0;
      read_clk_in_q   <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      exp_len_q       <= exp_len_d;
      power_enable_q  <= power_enable_d;
      erase_q         <= erase_d;
      expose_q        <= expose_d;
      write_enable_q  <= write_enable_d;
      counter_reset_q <= counter_reset_d;
      counter_clock_q <= counter_clock_d;
      read_reset_q    <= read_reset_d;
      read_clk_in_q   <= read_clk_in_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign POWER_ENABLE  = power_enable_q;
  assign ERASE         = erase_q;
  assign EXPOSE        = expose_q;
  assign WRITE_ENABLE  = write_enable_q;
  assign COUNTER_RESET = counter_reset_q;
  assign COUNTER_CLOCK = counter_clock_q;
  assign READ_RESET    = read_reset_q;
  assign READ_CLK_IN   = read_clk_in_q;
  assign BUSY          = busy_q;
  assign FRAME_DONE    = frame_done_q;

`ifdef PIXEL_ARRAY_SEQUENCER_FRAME_COUNTER_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Count advances on the same edge FRAME_DONE rises; wraps naturally at 16 bits
  always_comb begin
    frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Frame counter survives ABORT, cleared only by reset
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign FRAME_COUNT = frame_count_q;
`else
  assign FRAME_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_array_sequencer.sv
// tb/tb_pixel_array_sequencer.sv - self-checking bench for pixel_array_sequencer
module tb_pixel_array_sequencer;

  localparam int E     = 4;
  localparam int CONV  = 512;
  localparam int READS = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, cont;
  logic [15:0] et;
  logic        pe_o, erase_o, expose_o, we_o, cr_o, cc_o, rr_o, rclk_o, busy_o, fd_o;
  logic [15:0] fc_o;

  int tests = 0;
  int fails = 0;

  pixel_array_sequencer dut (
    .SYSTEM_CLK    (clk),
    .SYSTEM_RESET  (rst),
    .START         (start),
    .ABORT         (abort),
    .CONTINUOUS    (cont),
    .EXPOSE_TIME   (et),
    .POWER_ENABLE  (pe_o),
    .ERASE         (erase_o),
    .EXPOSE        (expose_o),
    .WRITE_ENABLE  (we_o),
    .COUNTER_RESET (cr_o),
    .COUNTER_CLOCK (cc_o),
    .READ_RESET    (rr_o),
    .READ_CLK_IN   (rclk_o),
    .BUSY          (busy_o),
    .FRAME_DONE    (fd_o),
    .FRAME_COUNT   (fc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame length from the accepting edge to the FRAME_DONE edge
  function automatic int frame_len(input int t);
    return 1 + E + t + 1 + CONV + 1 + READS;
  endfunction

  // Expected {pe, erase, expose, we, cr, cc, rr, rclk, busy, fd} at k edges after acceptance
  function automatic logic [9:0] phase(input int k, input int t);
    logic pe, er, ex, we, cr, cc, rr, rc;
    int   conv0, rdrst, l;
    pe = 0; er = 0; ex = 0; we = 0; cr = 0; cc = 0; rr = 0; rc = 0;
    conv0 = E + t + 2;
    rdrst = conv0 + CONV;
    l     = frame_len(t);
    if (k >= 1 && k <= E) er = 1;
    else if (k > E && k <= E + t) ex = 1;
    else if (k == E + t + 1) begin cr = 1; pe = 1; we = 1; end
    else if (k >= conv0 && k < rdrst) begin pe = 1; we = 1; cc = ((k - conv0) % 2 == 0); end
    else if (k == rdrst) rr = 1;
    else if (k > rdrst && k < l) rc = ((k - rdrst - 1) % 2 == 0);
    return {pe, er, ex, we, cr, cc, rr, rc, (k >= 1 && k <= l), (k == l)};
  endfunction

  // Behavioural model: a frame is an acceptance edge plus a latched exposure; outputs follow from the offset
  int          n = 0;
  bit          m_idle = 1;
  int          m_base = 0;
  int          m_t = 1;
  logic [9:0]  m_vec = '0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk) begin
    int k;
    n = n + 1;
    if (rst) begin
      m_idle = 1; m_vec = '0; m_cnt = '0;
    end else if (abort) begin
      m_idle = 1; m_vec = '0;
    end else if (m_idle) begin
      m_vec = '0;
      if (start) begin
        m_idle = 0; m_base = n; m_t = (et == 0) ? 1 : int'(et);
      end
    end else begin
      k = n - m_base;
      m_vec = phase(k, m_t);
      if (k == frame_len(m_t)) begin
        if (cont) begin
          m_base = n; m_t = (et == 0) ? 1 : int'(et);
        end else begin
          m_idle = 1;
        end
      end
    end
`ifdef PIXEL_ARRAY_SEQUENCER_FRAME_COUNTER_EN
    if (!rst && m_vec[0]) m_cnt = m_cnt + 16'd1;
`endif
  end

  // Compare every cycle, mid-period, plus the exclusivity invariant
  always @(negedge clk) begin
    logic [25:0] got, want;
    got  = {pe_o, erase_o, expose_o, we_o, cr_o, cc_o, rr_o, rclk_o, busy_o, fd_o, fc_o};
    want = {m_vec, m_cnt};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL outputs @edge %0d: got %h expected %h", n, got, want);
    end
    tests++;
    if (int'(erase_o) + int'(expose_o) + int'(we_o) > 1) begin
      fails++;
      $display("FAIL invariant @edge %0d: erase=%b expose=%b we=%b, at most one allowed", n, erase_o, expose_o, we_o);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int s, output int rel, output int ncc, output int nrc, output int ferase);
    rel = -1; ncc = 0; nrc = 0; ferase = -1;
    for (int i = 0; i < 2000 && rel < 0; i++) begin
      tick();
      if (erase_o && ferase < 0) ferase = n - s;
      ncc += int'(cc_o);
      nrc += int'(rclk_o);
      if (fd_o) rel = n - s;
    end
  endtask

  int s, rel, ncc, nrc, fe, nfd;

  initial begin
    rst = 1; start = 0; abort = 0; cont = 0; et = 16'd10;
    tick(); tick(); tick();
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_outputs", int'({pe_o, erase_o, expose_o, we_o, cr_o, cc_o, rr_o, rclk_o, fd_o}), 0);
    chk("reset_count", int'(fc_o), 0);
    rst = 0; tick();

    // Default frame, exposure 10
    start = 1; tick(); s = n; start = 0;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t1_erase_rise", fe, 1);
    chk("t1_done_edge", rel, 533);
    chk("t1_counter_clock_pulses", ncc, 256);
    chk("t1_read_clk_pulses", nrc, 2);
    tick();
    chk("t1_busy_after", int'(busy_o), 0);

    // Zero exposure behaves as one cycle
    et = 16'd0; start = 1; tick(); s = n; start = 0;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t2_done_edge", rel, 524);
    tick();

    // Continuous: two back-to-back frames
    rst = 1; tick(); rst = 0; tick();
    et = 16'd3; cont = 1; start = 1; tick(); s = n; start = 0;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t3_first_done", rel, 526);
    cont = 0; s = n;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t3_second_erase_rise", fe, 1);
    chk("t3_second_done", rel, 526);
`ifdef PIXEL_ARRAY_SEQUENCER_FRAME_COUNTER_EN
    chk("t3_frame_count", int'(fc_o), 2);
`else
    chk("t3_frame_count", int'(fc_o), 0);
`endif
    tick();

    // Abort during CONVERT
    et = 16'd10; start = 1; tick(); s = n; start = 0;
    while (n < s + 99) tick();
    abort = 1; tick(); abort = 0; tick();
    chk("t4_abort_edge", n - s, 101);
    chk("t4_abort_busy", int'(busy_o), 0);
    chk("t4_abort_outputs", int'({pe_o, erase_o, expose_o, we_o, cr_o, cc_o, rr_o, rclk_o, fd_o}), 0);
    nfd = 0;
    for (int i = 0; i < 600; i++) begin tick(); nfd += int'(fd_o); end
    chk("t4_no_frame_done", nfd, 0);
    start = 1; tick(); s = n; start = 0;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t4_fresh_frame_done", rel, 533);
    tick();

    // START held high, non-continuous
    start = 1; tick(); s = n;
    wait_done(s, rel, ncc, nrc, fe);
    chk("t5_done_edge", rel, 533);
    tick();
    chk("t5_idle_return", int'(busy_o), 0);
    tick();
    chk("t5_restart_erase", int'(erase_o), 1);
    start = 0; abort = 1; tick(); abort = 0; tick();

    // Five continuous frames, then reset in the middle of CONVERT
    rst = 1; tick(); rst = 0; tick();
    et = 16'd1; cont = 1; start = 1; tick(); s = n; start = 0;
    for (int f = 0; f < 5; f++) begin
      wait_done(s, rel, ncc, nrc, fe);
      chk("t6_frame_len", rel, 524);
      s = n;
    end
`ifdef PIXEL_ARRAY_SEQUENCER_FRAME_COUNTER_EN
    chk("t6_count_before_reset", int'(fc_o), 5);
`else
    chk("t6_count_before_reset", int'(fc_o), 0);
`endif
    while (n < s + 299) tick();
    chk("t6_in_convert", int'(we_o), 1);
    rst = 1; tick(); rst = 0; cont = 0; tick();
    chk("t6_reset_outputs", int'({pe_o, erase_o, expose_o, we_o, cr_o, cc_o, rr_o, rclk_o, busy_o, fd_o}), 0);
    chk("t6_reset_count", int'(fc_o), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      et    = 16'($urandom_range(0, 20));
      rst   = ($urandom_range(0, 2999) == 0);
      tick();
    end
    start = 0; abort = 0; rst = 0; cont = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
